// File: rtl/aes_kat_sequencer.sv
// Known-answer-test sequencer: steps one shared AES encrypt/decrypt core pair
// through the FIPS-197 128/192/256-bit vectors and latches a pass flag per key size.
module aes_kat_sequencer #(
  parameter int unsigned LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic [1:0]   key_sel,
  output logic [255:0] key_out,
  output logic [127:0] data_out,
  input  logic [127:0] enc_result,
  input  logic [127:0] dec_result,
  output logic         busy,
  output logic         done,
  output logic         outLed128,
  output logic         outLed192,
  output logic         outLed256,
  output logic         fail
);

  localparam logic [127:0] PLAINTEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY128    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] KEY192    = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KEY256    =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192     = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256     = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [7:0]   WCNT_INIT = 8'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  function automatic logic [255:0] key_for(input logic [1:0] sel);
    case (sel)
      2'd1:    return {64'b0, KEY192};
      2'd2:    return KEY256;
      default: return {128'b0, KEY128};
    endcase
  endfunction

  function automatic logic [127:0] ct_for(input logic [1:0] sel);
    case (sel)
      2'd1:    return CT192;
      2'd2:    return CT256;
      default: return CT128;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     wcnt_q, wcnt_d;
  logic           enable_q;
  logic [1:0]     key_sel_q, key_sel_d;
  logic [255:0]   key_out_q, key_out_d;
  logic [2:0]     leds_q, leds_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           start;
  logic           pass;

  assign start = enable & ~enable_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    key_sel_d = key_sel_q;
    key_out_d = key_out_q;
    leds_d    = leds_q;
    pass      = (enc_result == ct_for(idx_q)) && (dec_result == PLAINTEXT);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          idx_d     = 2'd0;
          leds_d    = '0;
          key_sel_d = 2'd0;
          key_out_d = key_for(2'd0);
        end
      end
      S_LOAD: begin
        wcnt_d  = WCNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == 8'd0) begin
          state_d = S_CHECK;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      S_CHECK: begin
        case (idx_q)
          2'd0:    leds_d[0] = pass;
          2'd1:    leds_d[1] = pass;
          default: leds_d[2] = pass;
        endcase
        if (idx_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          // Key registers are loaded on the edge entering LOAD so the core
          // sees a stable key for the whole LOAD..CHECK window.
          idx_d     = idx_q + 2'd1;
          key_sel_d = idx_q + 2'd1;
          key_out_d = key_for(idx_q + 2'd1);
          state_d   = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      wcnt_q    <= 8'd0;
      enable_q  <= 1'b0;
      key_sel_q <= 2'd0;
      key_out_q <= {128'b0, KEY128};
      leds_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      enable_q  <= enable;
      key_sel_q <= key_sel_d;
      key_out_q <= key_out_d;
      leds_q    <= leds_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign key_sel   = key_sel_q;
  assign key_out   = key_out_q;
  assign data_out  = PLAINTEXT;
  assign busy      = busy_q;
  assign done      = done_q;
  assign outLed128 = leds_q[0];
  assign outLed192 = leds_q[1];
  assign outLed256 = leds_q[2];
  assign fail      = done_q & ~(&leds_q);

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Bench for aes_kat_sequencer: two instances (LAT=4 and LAT=1) share enable/reset,
// each driven by a behavioural latency-modelled AES core with optional corruption.
module tb_aes_kat_sequencer;

  localparam int unsigned LAT_A = 4;
  localparam int unsigned LAT_B = 1;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] JUNK  = 128'hdeadbeef_cafef00d_0badc0de_55aa33cc;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;

  logic [1:0]   ks_a, ks_b;
  logic [255:0] ko_a, ko_b;
  logic [127:0] do_a, do_b, enc_a, dec_a, enc_b, dec_b;
  logic         busy_a, done_a, l128_a, l192_a, l256_a, fail_a;
  logic         busy_b, done_b, l128_b, l192_b, l256_b, fail_b;

  bit [2:0]     enc_mask = '0;
  bit [2:0]     dec_mask = '0;
  bit [2:0]     prev_pass = '0;
  int           cnt_a = 0, cnt_b = 0;
  logic [257:0] prev_a = 'x, prev_b = 'x;
  int           checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic [255:0] tb_key(input logic [1:0] ks);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < 16 + 8 * int'(ks); i++) k = (k << 8) | 256'(i);
    return k;
  endfunction

  function automatic logic [127:0] tb_ct(input logic [1:0] ks);
    case (ks)
      2'd0:    return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      2'd1:    return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: return 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
  endfunction

  // Core model: results valid once key_sel/key_out have been stable LAT cycles.
  function automatic logic [127:0] core_enc(input logic [1:0] ks, input logic [255:0] ko,
                                            input int cnt, input int lat, input bit [2:0] m);
    if (ks > 2'd2 || ko !== tb_key(ks) || cnt < lat + 1) return JUNK;
    return tb_ct(ks) ^ (m[ks] ? 128'h1 : 128'h0);
  endfunction

  function automatic logic [127:0] core_dec(input logic [1:0] ks, input logic [255:0] ko,
                                            input int cnt, input int lat, input bit [2:0] m);
    if (ks > 2'd2 || ko !== tb_key(ks) || cnt < lat + 1) return ~JUNK;
    return PT ^ (m[ks] ? 128'h20 : 128'h0);
  endfunction

  assign enc_a = core_enc(ks_a, ko_a, cnt_a, LAT_A, enc_mask);
  assign dec_a = core_dec(ks_a, ko_a, cnt_a, LAT_A, dec_mask);
  assign enc_b = core_enc(ks_b, ko_b, cnt_b, LAT_B, enc_mask);
  assign dec_b = core_dec(ks_b, ko_b, cnt_b, LAT_B, dec_mask);

  always @(negedge clk) begin
    if ({ks_a, ko_a} !== prev_a) cnt_a = 1; else if (cnt_a < 10000) cnt_a++;
    prev_a = {ks_a, ko_a};
    if ({ks_b, ko_b} !== prev_b) cnt_b = 1; else if (cnt_b < 10000) cnt_b++;
    prev_b = {ks_b, ko_b};
  end

  aes_kat_sequencer #(.LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .key_sel(ks_a), .key_out(ko_a),
    .data_out(do_a), .enc_result(enc_a), .dec_result(dec_a), .busy(busy_a),
    .done(done_a), .outLed128(l128_a), .outLed192(l192_a), .outLed256(l256_a),
    .fail(fail_a)
  );

  aes_kat_sequencer #(.LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .key_sel(ks_b), .key_out(ko_b),
    .data_out(do_b), .enc_result(enc_b), .dec_result(dec_b), .busy(busy_b),
    .done(done_b), .outLed128(l128_b), .outLed192(l192_b), .outLed256(l256_b),
    .fail(fail_b)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string pfx, input logic busy, input logic done,
                             input logic [1:0] ks, input logic [255:0] ko,
                             input logic [2:0] leds, input logic fail);
    check({pfx, " rst busy"}, 256'(busy), 256'(0));
    check({pfx, " rst done"}, 256'(done), 256'(0));
    check({pfx, " rst key_sel"}, 256'(ks), 256'(0));
    check({pfx, " rst key_out"}, ko, tb_key(2'd0));
    check({pfx, " rst leds"}, 256'(leds), 256'(0));
    check({pfx, " rst fail"}, 256'(fail), 256'(0));
  endtask

  // t = number of edges after the start edge E0 (t=0 is sampled just after E0).
  task automatic check_exp(input string pfx, input int t, input int p, input bit [2:0] pass,
                           input logic busy, input logic done, input logic [1:0] ks,
                           input logic [255:0] ko, input logic [2:0] leds, input logic fail);
    bit [2:0] exp_leds;
    bit       running;
    running = (t < 3 * p);
    for (int i = 0; i < 3; i++) exp_leds[i] = (t >= (i + 1) * p) ? pass[i] : 1'b0;
    check($sformatf("%s t=%0d busy", pfx, t), 256'(busy), 256'(running));
    check($sformatf("%s t=%0d done", pfx, t), 256'(done), 256'(!running));
    check($sformatf("%s t=%0d leds", pfx, t), 256'(leds), 256'(exp_leds));
    check($sformatf("%s t=%0d fail", pfx, t), 256'(fail), 256'(!running && pass != 3'b111));
    if (running) begin
      check($sformatf("%s t=%0d key_sel", pfx, t), 256'(ks), 256'(t / p));
      check($sformatf("%s t=%0d key_out", pfx, t), ko, tb_key(2'(t / p)));
    end
  endtask

  task automatic check_idle(input string pfx, input bit from_done, input logic busy,
                            input logic done, input logic [2:0] leds, input logic fail);
    check({pfx, " gap busy"}, 256'(busy), 256'(0));
    check({pfx, " gap done"}, 256'(done), 256'(from_done));
    check({pfx, " gap leds"}, 256'(leds), from_done ? 256'(prev_pass) : 256'(0));
    check({pfx, " gap fail"}, 256'(fail), 256'(from_done && prev_pass != 3'b111));
  endtask

  task automatic do_run(input bit [2:0] em, input bit [2:0] dm, input bit retrig,
                        input int rst_at, input bit from_done);
    bit [2:0] pass;
    int       t;
    bit       rst_pending;
    pass   = ~(em | dm);
    enable = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      check_idle("A", from_done, busy_a, done_a, {l256_a, l192_a, l128_a}, fail_a);
      check_idle("B", from_done, busy_b, done_b, {l256_b, l192_b, l128_b}, fail_b);
    end
    enc_mask    = em;
    dec_mask    = dm;
    enable      = 1'b1;
    rst_pending = (rst_at > 0);
    t = -1;
    while (t < 3 * int'(LAT_A + 2) + 1) begin
      @(negedge clk);
      t++;
      if (rst_pending && t == rst_at) begin
        check_reset("A", busy_a, done_a, ks_a, ko_a, {l256_a, l192_a, l128_a}, fail_a);
        check_reset("B", busy_b, done_b, ks_b, ko_b, {l256_b, l192_b, l128_b}, fail_b);
        rst         = 1'b0;
        rst_pending = 1'b0;
        t           = -1;
        continue;
      end
      check_exp("A", t, LAT_A + 2, pass, busy_a, done_a, ks_a, ko_a,
                {l256_a, l192_a, l128_a}, fail_a);
      check_exp("B", t, LAT_B + 2, pass, busy_b, done_b, ks_b, ko_b,
                {l256_b, l192_b, l128_b}, fail_b);
      if (retrig && t == 4) enable = 1'b0;
      if (retrig && t == 6) enable = 1'b1;
      if (rst_pending && t == rst_at - 1) rst = 1'b1;
    end
    prev_pass = pass;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit [2:0] em, dm;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("A", busy_a, done_a, ks_a, ko_a, {l256_a, l192_a, l128_a}, fail_a);
    check_reset("B", busy_b, done_b, ks_b, ko_b, {l256_b, l192_b, l128_b}, fail_b);
    check("A data_out", 256'(do_a), 256'(PT));
    check("B data_out", 256'(do_b), 256'(PT));
    rst = 1'b0;

    do_run(3'b000, 3'b000, 1'b0, 0, 1'b0);
    do_run(3'b010, 3'b000, 1'b0, 0, 1'b1);
    do_run(3'b000, 3'b100, 1'b0, 0, 1'b1);
    do_run(3'b000, 3'b000, 1'b1, 0, 1'b1);
    do_run(3'b000, 3'b000, 1'b0, 10, 1'b1);
    for (int i = 0; i < 6; i++) begin
      em = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      dm = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      do_run(em, dm, 1'($urandom_range(0, 1)), 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
